rf_wr_arbiter: RTL

Two-requester write-port arbiter for the 8 x DATA_WIDTH register file (`rf`). It shares the register file's single write port between writeback requester A (ALU writeback) and requester B (load return) using per-cycle round-robin arbitration. It drives the rf write bus from registered outputs and checks both requesters' handshakes for protocol violations. It sits between the writeback stage and the `rf` write inputs.

---
 rtl/rf_wr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single rf write port between ALU writeback (A)
// and load return (B), with registered write bus and sticky handshake-error flag.
module rf_wr_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [2:0]            a_regsel,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [2:0]            b_regsel,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ack,
  output logic [2:0]            writeregsel,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  write,
  output logic [7:0]            wr_mask,
  output logic                  err
);

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic                  last_grant_q, last_grant_d;
  logic                  write_q, write_d;
  logic [2:0]            regsel_q, regsel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  a_wait_q, a_wait_d;
  logic                  b_wait_q, b_wait_d;
  logic [2:0]            a_sel_q, b_sel_q;
  logic [DATA_WIDTH-1:0] a_dat_q, b_dat_q;
  logic                  a_viol, b_viol;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    a_ack = a_req & (~b_req | (last_grant_q == GNT_B));
    b_ack = b_req & (~a_req | (last_grant_q == GNT_A));
  end

  // A waiting requester must hold req, regsel and data until it sees its ack.
  always_comb begin
    a_viol = a_wait_q & (~a_req | (a_regsel != a_sel_q) | (a_data != a_dat_q));
    b_viol = b_wait_q & (~b_req | (b_regsel != b_sel_q) | (b_data != b_dat_q));
  end

  always_comb begin
    last_grant_d = last_grant_q;
    regsel_d     = regsel_q;
    data_d       = data_q;
    write_d      = a_ack | b_ack;
    if (a_ack) begin
      last_grant_d = GNT_A;
      regsel_d     = a_regsel;
      data_d       = a_data;
    end else if (b_ack) begin
      last_grant_d = GNT_B;
      regsel_d     = b_regsel;
      data_d       = b_data;
    end
    a_wait_d = a_req & ~a_ack;
    b_wait_d = b_req & ~b_ack;
    err_d    = err_q | a_viol | b_viol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_B;
      write_q      <= 1'b0;
      regsel_q     <= 3'd0;
      data_q       <= '0;
      err_q        <= 1'b0;
      a_wait_q     <= 1'b0;
      b_wait_q     <= 1'b0;
      a_sel_q      <= 3'd0;
      b_sel_q      <= 3'd0;
      a_dat_q      <= '0;
      b_dat_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      regsel_q     <= regsel_d;
      data_q       <= data_d;
      err_q        <= err_d;
      a_wait_q     <= a_wait_d;
      b_wait_q     <= b_wait_d;
      a_sel_q      <= a_regsel;
      b_sel_q      <= b_regsel;
      a_dat_q      <= a_data;
      b_dat_q      <= b_data;
    end
  end

  always_comb begin
    wr_mask = 8'h00;
    if (write_q) wr_mask[regsel_q] = 1'b1;
  end

  assign write       = write_q;
  assign writeregsel = regsel_q;
  assign writedata   = data_q;
  assign err         = err_q;

endmodule
